// File: rtl/binary_div_bi.sv
// Sequential signed restoring divider, constant latency, start/busy/done.
// Recovers quotient and remainder of a DW-bit dividend by a VW-bit divisor.
module binary_div_bi #(
  parameter int DW = 5,
  parameter int VW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic          ovf
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0] a_q;
  logic [VW-1:0] b_q;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dsr;
  logic [VW-1:0] rem;
  logic [CW-1:0] cnt;
  logic          neg_a;
  logic          neg_q;

  logic          accept;
  logic [VW:0]   rem_sh;
  logic          fits;
  logic          is_ovf;

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign busy   = (state == S_PREP) || (state == S_ITER) || (state == S_FIX);
  assign done   = (state == S_DONE);

  // Magnitudes are unsigned here, so |most-negative| fits without a sign bit.
  assign rem_sh = {rem, dvd[DW-1]};
  assign fits   = rem_sh >= {1'b0, dsr};
  assign is_ovf = (a_q == {1'b1, {(DW-1){1'b0}}}) && (b_q == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else if (en)
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_PREP;
      S_PREP: state_nx = S_ITER;
      S_ITER: if (cnt == CW'(DW-1)) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = start ? S_PREP : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      dvd   <= '0;
      dsr   <= '0;
      rem   <= '0;
      cnt   <= '0;
      neg_a <= 1'b0;
      neg_q <= 1'b0;
      Q     <= '0;
      R     <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else if (en) begin
      if (accept) begin
        a_q <= A;
        b_q <= B;
      end
      unique case (state)
        S_PREP: begin
          dvd   <= a_q[DW-1] ? -a_q : a_q;
          dsr   <= b_q[VW-1] ? -b_q : b_q;
          rem   <= '0;
          cnt   <= '0;
          neg_a <= a_q[DW-1];
          neg_q <= a_q[DW-1] ^ b_q[VW-1];
        end
        S_ITER: begin
          rem <= fits ? VW'(rem_sh - {1'b0, dsr}) : VW'(rem_sh);
          dvd <= {dvd[DW-2:0], fits};
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (b_q == '0) begin
            Q   <= '0;
            R   <= '0;
            dz  <= 1'b1;
            ovf <= 1'b0;
          end else begin
            Q   <= neg_q ? -dvd : dvd;
            R   <= neg_a ? -rem : rem;
            dz  <= 1'b0;
            ovf <= is_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_div_bi.sv
// Self-checking bench for binary_div_bi.
// Results are compared with native signed integer division.
module tb_binary_div_bi;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       start;
  logic [4:0] A;
  logic [2:0] B;
  logic [4:0] Q;
  logic [2:0] R;
  logic       busy;
  logic       done;
  logic       dz;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  binary_div_bi #(.DW(5), .VW(3)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .A(A), .B(B), .Q(Q), .R(R),
    .busy(busy), .done(done), .dz(dz), .ovf(ovf)
  );

  function automatic logic [9:0] model(input int a, input int b);
    int q, r;
    logic d, o;
    d = 0; o = 0;
    if (b == 0) begin
      q = 0; r = 0; d = 1;
    end else if (a == -16 && b == -1) begin
      q = -16; r = 0; o = 1;
    end else begin
      q = a / b; r = a % b;
    end
    return {5'(q), 3'(r), d, o};
  endfunction

  function automatic logic [9:0] got();
    return {Q, R, dz, ovf};
  endfunction

  // Issue one operation; lat = enabled edges from accept to done, -1 on timeout.
  task automatic do_op(input int a, input int b, output int lat);
    @(negedge clk);
    A = 5'(a); B = 3'(b); start = 1;
    @(posedge clk);
    #1 start = 0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 1; start = 0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({got(), busy, done} !== 12'd0) begin
      errors++;
      $display("FAIL reset: got %h required 000", {got(), busy, done});
    end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_directed();
    int va[5] = '{13, -13, 7, -16, 9};
    int vb[5] = '{3, 3, -2, -1, 0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], lat);
      checks++;
      if (lat != 7) begin
        errors++;
        $display("FAIL dir_lat %0d/%0d: got %0d required 7", va[i], vb[i], lat);
      end
      checks++;
      if (got() !== model(va[i], vb[i])) begin
        errors++;
        $display("FAIL dir_res %0d/%0d: got %b required %b",
                 va[i], vb[i], got(), model(va[i], vb[i]));
      end
    end
  endtask

  task automatic test_sweep();
    int lat, qi, ri, bi;
    for (int a = -16; a <= 15; a++) begin
      for (int b = -4; b <= 3; b++) begin
        do_op(a, b, lat);
        checks++;
        if (lat != 7 || got() !== model(a, b)) begin
          errors++;
          $display("FAIL sweep %0d/%0d: got %b lat %0d required %b lat 7",
                   a, b, got(), lat, model(a, b));
        end
        if (!dz && !ovf) begin
          qi = int'($signed(Q)); ri = int'($signed(R)); bi = b;
          checks++;
          if (qi * bi + ri != a ||
              (ri < 0 ? -ri : ri) >= (bi < 0 ? -bi : bi) ||
              (ri != 0 && ((ri < 0) != (a < 0)))) begin
            errors++;
            $display("FAIL sweep_rules %0d/%0d: got q=%0d r=%0d", a, b, qi, ri);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int a, b, lat;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 31)) - 16;
      b = int'($urandom_range(0, 7)) - 4;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_op(a, b, lat);
      checks++;
      if (lat != 7 || got() !== model(a, b)) begin
        errors++;
        $display("FAIL random %0d/%0d: got %b lat %0d required %b lat 7",
                 a, b, got(), lat, model(a, b));
      end
    end
  endtask

  task automatic test_busy_start();
    int lat;
    bit extra;
    @(negedge clk);
    A = 5'd13; B = 3'd3; start = 1;
    @(posedge clk);
    #1 start = 0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept: got %b required 1", busy);
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 2) begin
        A = 5'd1; B = 3'd1; start = 1;
      end else
        start = 0;
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 7 || got() !== model(13, 3)) begin
      errors++;
      $display("FAIL busy_ignore: got %b lat %0d required %b lat 7",
               got(), lat, model(13, 3));
    end
    extra = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (done || busy) extra = 1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL busy_no_queue: got extra activity required none");
    end
  endtask

  task automatic test_enable_stall();
    int lat;
    logic [9:0] prev;
    bit bad;
    prev = got();
    bad = 0;
    @(negedge clk);
    A = 5'b10011; B = 3'd3; start = 1;
    @(posedge clk);
    #1 start = 0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk) en = !(n >= 4 && n <= 6);
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (got() !== prev) bad = 1;
    end
    checks++;
    if (lat != 10 || got() !== model(-13, 3)) begin
      errors++;
      $display("FAIL en_stall: got %b lat %0d required %b lat 10",
               got(), lat, model(-13, 3));
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL en_hold: got output change required hold");
    end
    @(negedge clk) en = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL en_done_freeze: got %b required 1", done);
    end
    @(negedge clk) en = 1;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: got %b required 0", done);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit held;
    do_op(7, -2, lat);
    checks++;
    if (lat != 7 || got() !== model(7, -2)) begin
      errors++;
      $display("FAIL b2b_first: got %b lat %0d", got(), lat);
    end
    A = 5'd9; B = 3'd2; start = 1;
    @(posedge clk);
    #1 start = 0;
    held = 1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (got() !== model(7, -2)) held = 0;
    end
    checks++;
    if (lat != 7 || got() !== model(9, 2)) begin
      errors++;
      $display("FAIL b2b_second: got %b lat %0d required %b lat 7",
               got(), lat, model(9, 2));
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL b2b_hold: got early output change required hold");
    end
  endtask

  task automatic test_rst_mid();
    bit seen;
    @(negedge clk);
    A = 5'd13; B = 3'd3; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1;
    checks++;
    if ({got(), busy, done} !== 12'd0) begin
      errors++;
      $display("FAIL rst_mid: got %h required 000", {got(), busy, done});
    end
    @(negedge clk) rst = 0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (done || busy) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_no_done: got done/busy required none");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_random();
    test_busy_start();
    test_enable_stall();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
